dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port between the CPU load/store path and a debug/loader master.
//  Sequences each access as request -> issue -> wait -> acknowledge, and produces the CPU stall.
//  Uses 2-way round-robin arbitration. Sits between cpu (d_addr/d_datain/memop/memwr/d_dataout) and the dmem.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  MEM_LAT  1   dmem read latency in cycles, 0..7 (cycles from issue to valid mem_rdata)
// PORTS
//  CPU_CLK    in   1       single clock, all state updates on posedge
//  rst        in   1       synchronous reset, active-high
//  cpu_req    in   1       CPU access request; held high until cpu_ack
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU store data
//  cpu_memop  in   3       CPU memop (byte/half/word, signed/unsigned)
//  cpu_memwr  in   1       1=store, 0=load
//  cpu_rdata  out  DATA_W  registered load data, valid when cpu_ack=1
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_stall  out  1       cpu_req & ~cpu_ack (combinational)
//  dbg_req/dbg_addr/dbg_wdata/dbg_memop/dbg_memwr/dbg_rdata/dbg_ack  same roles, for the debug master
//  mem_addr   out  ADDR_W  to dmem
//  mem_wdata  out  DATA_W  to dmem
//  mem_memop  out  3       to dmem
//  mem_memwr  out  1       dmem write strobe
//  mem_rdata  in   DATA_W  from dmem
//  perf_cpu_cnt/perf_dbg_cnt/perf_conf_cnt  out  32  counters (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, last_owner=DBG (CPU wins first tie).
//    Reset values: all acks 0, mem_memwr 0, mem_addr/wdata/memop 0, cpu_rdata/dbg_rdata 0, counters 0.
//  - FSM states: IDLE, ISSUE, WAIT, DONE.
//      IDLE:  any req -> ISSUE; latch owner and the owner's addr/wdata/memop/memwr.
//      ISSUE: mem_* driven from latched values; mem_memwr = latched wr for exactly this cycle.
//             MEM_LAT=0 -> DONE, else -> WAIT with wait_cnt = MEM_LAT-1.
//      WAIT:  mem_* held, mem_memwr=0. Decrement; at wait_cnt==0 capture mem_rdata -> owner rdata, -> DONE.
//             (MEM_LAT=0: capture in ISSUE.)
//      DONE:  owner ack=1 for one cycle; last_owner=owner; -> IDLE.
//  - Latency: req high in cycle 0 (IDLE) -> ISSUE cycle 1 -> ack in cycle 2+MEM_LAT.
//    Throughput: one access per 3+MEM_LAT cycles.
//  - Arbitration: only one req -> grant it. Both req -> grant the one != last_owner.
//    Decided only in IDLE; never preempts.
//  - Requests are sampled only in IDLE. Address/data may change after ISSUE without effect.
//  - Requester drops req mid-transaction: access still completes and ack still pulses. Stores are never aborted.
//  - Non-owner rdata holds its previous value. Writes leave rdata unchanged.
//  - rst asserted in any state: next cycle IDLE, no ack. A write in ISSUE that same cycle is suppressed
//    (mem_memwr gated by ~rst).
//  - mem_* outputs in IDLE/DONE: hold last latched address, mem_memwr=0.
// CONFIGURATION
//  DMEM_ARB_PERF_EN defined:
//    perf_cpu_cnt++ per CPU DONE; perf_dbg_cnt++ per DBG DONE.
//    perf_conf_cnt++ each IDLE cycle with both reqs high. All wrap at 2^32; cleared by rst.
//  Undefined: the three perf ports exist but are tied to 0; no counter flops.
// STRUCTURE
//  dmem_arb_pkg: state enum (IDLE/ISSUE/WAIT/DONE), owner encoding (OWN_CPU=0, OWN_DBG=1),
//    memop constants shared with ctrl_gen.
//  Sub-module rr_arb2: 2-input round-robin picker (req[1:0], last_owner -> gnt, owner); combinational.
// TESTING
//  1 CPU load, MEM_LAT=1, addr 0x100, mem returns 0xDEADBEEF -> cpu_ack at cycle 3, cpu_rdata=0xDEADBEEF, stall cycles 0-2.
//  2 CPU store 0x12345678 to 0x40 -> mem_memwr=1 only in cycle 1, mem_addr=0x40; cpu_ack cycle 3; dbg_ack never.
//  3 Both req from reset, held -> CPU served first, then DBG; acks alternate CPU,DBG,CPU...
//  4 DBG drops req in WAIT -> dbg_ack still pulses once; FSM returns to IDLE; no extra mem_memwr.
//  5 rst in ISSUE of a store -> mem_memwr=0 that cycle, state IDLE next, no ack, outputs at reset values.
//  6 DMEM_ARB_PERF_EN, 4 contended rounds -> perf_cpu_cnt=4, perf_dbg_cnt=4, perf_conf_cnt>=4; without macro all 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding and memop codes.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  // memop encodings shared with ctrl_gen
  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone request wins, a tie goes to the side that did not own last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic [1:0] gnt,
  output owner_t     owner
);

  always_comb begin
    gnt   = '0;
    owner = OWN_CPU;
    if (req[0] && (!req[1] || last_owner == OWN_DBG)) begin
      gnt   = 2'b01;
      owner = OWN_CPU;
    end else if (req[1]) begin
      gnt   = 2'b10;
      owner = OWN_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the dmem port between the CPU and the debug/loader master (IDLE->ISSUE->WAIT->DONE).
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CPU_CLK,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_memop,
  input  logic              cpu_memwr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [2:0]        dbg_memop,
  input  logic              dbg_memwr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_memop,
  output logic              mem_memwr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_cpu_cnt,
  output logic [31:0]       perf_dbg_cnt,
  output logic [31:0]       perf_conf_cnt
);

  localparam logic [2:0] LAT_M1 = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

  state_t     state;
  owner_t     owner;
  owner_t     last_owner;
  owner_t     pick_owner;
  logic [1:0] gnt;
  logic       lat_wr;
  logic [2:0] wait_cnt;
  logic       capture;

  rr_arb2 u_arb (
    .req        ({dbg_req, cpu_req}),
    .last_owner (last_owner),
    .gnt        (gnt),
    .owner      (pick_owner)
  );

  // Last cycle before DONE: read data is valid here, and the ack is registered from it.
  always_comb begin
    capture = 1'b0;
    if (state == ISSUE && MEM_LAT == 0)
      capture = 1'b1;
    else if (state == WAIT && wait_cnt == '0)
      capture = 1'b1;
  end

  always_ff @(posedge CPU_CLK) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_DBG;
      lat_wr     <= 1'b0;
      wait_cnt   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_memop  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      if (capture) begin
        cpu_ack <= (owner == OWN_CPU);
        dbg_ack <= (owner == OWN_DBG);
        if (!lat_wr) begin
          if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
          else                  dbg_rdata <= mem_rdata;
        end
      end
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner <= pick_owner;
            if (gnt[1]) begin
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
              mem_memop <= dbg_memop;
              lat_wr    <= dbg_memwr;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_memop <= cpu_memop;
              lat_wr    <= cpu_memwr;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_LAT == 0) begin
            state <= DONE;
          end else begin
            wait_cnt <= LAT_M1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= DONE;
          else                wait_cnt <= wait_cnt - 3'd1;
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write strobe is gated by rst so a store caught in ISSUE never reaches memory.
  assign mem_memwr = (state == ISSUE) && lat_wr && !rst;
  assign cpu_stall = cpu_req && !cpu_ack;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge CPU_CLK) begin
    if (rst) begin
      perf_cpu_cnt  <= '0;
      perf_dbg_cnt  <= '0;
      perf_conf_cnt <= '0;
    end else begin
      if (state == DONE && owner == OWN_CPU) perf_cpu_cnt <= perf_cpu_cnt + 32'd1;
      if (state == DONE && owner == OWN_DBG) perf_dbg_cnt <= perf_dbg_cnt + 32'd1;
      if (state == IDLE && cpu_req && dbg_req) perf_conf_cnt <= perf_conf_cnt + 32'd1;
    end
  end
`else
  assign perf_cpu_cnt  = '0;
  assign perf_dbg_cnt  = '0;
  assign perf_conf_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter (MEM_LAT=1) with a registered-read memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_memwr, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_memop;
  logic        dbg_req, dbg_memwr, dbg_ack;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [2:0]  dbg_memop;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_memop;
  logic        mem_memwr;
  logic [31:0] perf_cpu_cnt, perf_dbg_cnt, perf_conf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .CPU_CLK(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_memop(cpu_memop),
    .cpu_memwr(cpu_memwr), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_memop(dbg_memop),
    .dbg_memwr(dbg_memwr), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memop(mem_memop), .mem_memwr(mem_memwr),
    .mem_rdata(mem_rdata),
    .perf_cpu_cnt(perf_cpu_cnt), .perf_dbg_cnt(perf_dbg_cnt), .perf_conf_cnt(perf_conf_cnt)
  );

  // Memory model: one-cycle registered read, preloaded while rst is high.
  logic [31:0] mem [256];
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  always @(posedge clk) begin
    if (rst) begin
      mem[32]  <= 32'h0BADC0DE;
      mem[64]  <= 32'hDEADBEEF;
      mem[128] <= 32'hCAFEF00D;
    end
    if (mem_memwr) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      last_wr_addr       <= mem_addr;
      last_wr_data       <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[9:2]];
  end

  typedef struct {
    logic r, creq; logic [31:0] ca, cw; logic [2:0] cop; logic cwr;
    logic dreq; logic [31:0] da, dw; logic [2:0] dop; logic dwr;
    logic e_cack, e_dack, e_cst, e_mwr; logic [31:0] e_maddr; logic [2:0] e_mop;
    logic [31:0] e_crd, e_drd;
  } vec_t;
  vec_t vt[$];

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam logic [31:0] Z = 32'h0;

  task automatic add(input logic r, creq, input logic [31:0] ca, cw, input logic [2:0] cop,
                     input logic cwr, dreq, input logic [31:0] da, dw, input logic [2:0] dop,
                     input logic dwr, ecack, edack, ecst, emwr, input logic [31:0] emaddr,
                     input logic [2:0] emop, input logic [31:0] ecrd, edrd);
    vec_t v;
    v.r = r; v.creq = creq; v.ca = ca; v.cw = cw; v.cop = cop; v.cwr = cwr;
    v.dreq = dreq; v.da = da; v.dw = dw; v.dop = dop; v.dwr = dwr;
    v.e_cack = ecack; v.e_dack = edack; v.e_cst = ecst; v.e_mwr = emwr;
    v.e_maddr = emaddr; v.e_mop = emop; v.e_crd = ecrd; v.e_drd = edrd;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_memop = '0; cpu_memwr = 1'b0;
    dbg_req = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_memop = '0; dbg_memwr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_dack, n_cack, n_wr, dack_cyc, wr_cyc, ack_cyc;
    logic [31:0] e_pc, e_pd, e_pf;

    // T1 CPU load, T2 CPU store, then (after a mid-run reset) T3 contended loads.
    add(I,O,Z,Z,3'd0,O, O,Z,Z,3'd0,O, O,O,O,O, Z,3'd0, Z,Z);
    add(O,I,32'h100,Z,MEMOP_LW,O, O,Z,Z,3'd0,O, O,O,I,O, Z,3'd0, Z,Z);
    add(O,I,32'h100,Z,MEMOP_LW,O, O,Z,Z,3'd0,O, O,O,I,O, 32'h100,MEMOP_LW, Z,Z);
    add(O,I,32'h100,Z,MEMOP_LW,O, O,Z,Z,3'd0,O, O,O,I,O, 32'h100,MEMOP_LW, Z,Z);
    add(O,I,32'h100,Z,MEMOP_LW,O, O,Z,Z,3'd0,O, I,O,O,O, 32'h100,MEMOP_LW, 32'hDEADBEEF,Z);
    add(O,O,Z,Z,3'd0,O, O,Z,Z,3'd0,O, O,O,O,O, 32'h100,MEMOP_LW, 32'hDEADBEEF,Z);
    add(O,I,32'h40,32'h12345678,MEMOP_LH,I, O,Z,Z,3'd0,O, O,O,I,O, 32'h100,MEMOP_LW, 32'hDEADBEEF,Z);
    add(O,I,32'h40,32'h12345678,MEMOP_LH,I, O,Z,Z,3'd0,O, O,O,I,I, 32'h40,MEMOP_LH, 32'hDEADBEEF,Z);
    add(O,I,32'h40,32'h12345678,MEMOP_LH,I, O,Z,Z,3'd0,O, O,O,I,O, 32'h40,MEMOP_LH, 32'hDEADBEEF,Z);
    add(O,I,32'h40,32'h12345678,MEMOP_LH,I, O,Z,Z,3'd0,O, I,O,O,O, 32'h40,MEMOP_LH, 32'hDEADBEEF,Z);
    add(O,O,Z,Z,3'd0,O, O,Z,Z,3'd0,O, O,O,O,O, 32'h40,MEMOP_LH, 32'hDEADBEEF,Z);
    // synchronous reset: registers still show old values during the rst cycle
    add(I,O,Z,Z,3'd0,O, O,Z,Z,3'd0,O, O,O,O,O, 32'h40,MEMOP_LH, 32'hDEADBEEF,Z);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,O,I,O, Z,3'd0, Z,Z);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,O,I,O, 32'h80,MEMOP_LBU, Z,Z);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,O,I,O, 32'h80,MEMOP_LBU, Z,Z);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, I,O,O,O, 32'h80,MEMOP_LBU, 32'h0BADC0DE,Z);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,O,I,O, 32'h80,MEMOP_LBU, 32'h0BADC0DE,Z);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,O,I,O, 32'h200,MEMOP_LHU, 32'h0BADC0DE,Z);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,O,I,O, 32'h200,MEMOP_LHU, 32'h0BADC0DE,Z);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,I,I,O, 32'h200,MEMOP_LHU, 32'h0BADC0DE,32'hCAFEF00D);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,O,I,O, 32'h200,MEMOP_LHU, 32'h0BADC0DE,32'hCAFEF00D);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,O,I,O, 32'h80,MEMOP_LBU, 32'h0BADC0DE,32'hCAFEF00D);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, O,O,I,O, 32'h80,MEMOP_LBU, 32'h0BADC0DE,32'hCAFEF00D);
    add(O,I,32'h80,Z,MEMOP_LBU,O, I,32'h200,Z,MEMOP_LHU,O, I,O,O,O, 32'h80,MEMOP_LBU, 32'h0BADC0DE,32'hCAFEF00D);
    add(O,O,Z,Z,3'd0,O, O,Z,Z,3'd0,O, O,O,O,O, 32'h80,MEMOP_LBU, 32'h0BADC0DE,32'hCAFEF00D);

    rst = 1'b1;
    idle_inputs();
    tick();
    tick();

    foreach (vt[i]) begin
      tick();
      rst = vt[i].r;
      cpu_req = vt[i].creq; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cw;
      cpu_memop = vt[i].cop; cpu_memwr = vt[i].cwr;
      dbg_req = vt[i].dreq; dbg_addr = vt[i].da; dbg_wdata = vt[i].dw;
      dbg_memop = vt[i].dop; dbg_memwr = vt[i].dwr;
      @(negedge clk);
      check($sformatf("row%0d cpu_ack", i), {31'd0, cpu_ack}, {31'd0, vt[i].e_cack});
      check($sformatf("row%0d dbg_ack", i), {31'd0, dbg_ack}, {31'd0, vt[i].e_dack});
      check($sformatf("row%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, vt[i].e_cst});
      check($sformatf("row%0d mem_memwr", i), {31'd0, mem_memwr}, {31'd0, vt[i].e_mwr});
      check($sformatf("row%0d mem_addr", i), mem_addr, vt[i].e_maddr);
      check($sformatf("row%0d mem_memop", i), {29'd0, mem_memop}, {29'd0, vt[i].e_mop});
      check($sformatf("row%0d cpu_rdata", i), cpu_rdata, vt[i].e_crd);
      check($sformatf("row%0d dbg_rdata", i), dbg_rdata, vt[i].e_drd);
    end
`ifdef DMEM_ARB_PERF_EN
    e_pc = 32'd2; e_pd = 32'd1; e_pf = 32'd3;
`else
    e_pc = 32'd0; e_pd = 32'd0; e_pf = 32'd0;
`endif
    check("t3 perf_cpu_cnt", perf_cpu_cnt, e_pc);
    check("t3 perf_dbg_cnt", perf_dbg_cnt, e_pd);
    check("t3 perf_conf_cnt", perf_conf_cnt, e_pf);
    check("t2 store addr", last_wr_addr, 32'h40);
    check("t2 store data", last_wr_data, 32'h12345678);

    // T4: debug store whose requester drops req while in WAIT
    tick(); rst = 1'b1; idle_inputs();
    dbg_addr = 32'h84; dbg_wdata = 32'h55AA55AA; dbg_memop = MEMOP_LW; dbg_memwr = 1'b1;
    n_dack = 0; n_cack = 0; n_wr = 0; dack_cyc = -1; wr_cyc = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      rst = 1'b0;
      dbg_req = (k < 2);
      @(negedge clk);
      if (dbg_ack) begin n_dack++; dack_cyc = k; end
      if (cpu_ack) n_cack++;
      if (mem_memwr) begin n_wr++; wr_cyc = k; end
    end
    check("t4 dbg_ack pulses", n_dack, 1);
    check("t4 dbg_ack cycle", dack_cyc, 3);
    check("t4 cpu_ack pulses", n_cack, 0);
    check("t4 mem_memwr pulses", n_wr, 1);
    check("t4 mem_memwr cycle", wr_cyc, 1);
    check("t4 store data", last_wr_data, 32'h55AA55AA);
    ack_cyc = 99;
    idle_inputs();
    for (int k = 0; k < 20 && ack_cyc == 99; k++) begin
      tick();
      cpu_req = 1'b1; cpu_addr = 32'h100; cpu_memop = MEMOP_LW;
      @(negedge clk);
      if (cpu_ack) ack_cyc = k;
    end
    check("t4 followup cpu_ack cycle", ack_cyc, 3);
    check("t4 followup cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // T5: reset hits the ISSUE cycle of a store
    tick(); idle_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h77; cpu_memop = MEMOP_LW; cpu_memwr = 1'b1;
    tick(); rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("t5 mem_memwr under rst", {31'd0, mem_memwr}, 32'd0);
    tick(); rst = 1'b0; idle_inputs();
    @(negedge clk);
    check("t5 mem_addr reset", mem_addr, 32'h0);
    check("t5 mem_wdata reset", mem_wdata, 32'h0);
    check("t5 mem_memop reset", {29'd0, mem_memop}, 32'd0);
    check("t5 cpu_rdata reset", cpu_rdata, 32'h0);
    check("t5 dbg_rdata reset", dbg_rdata, 32'h0);
    n_cack = 0; n_dack = 0; n_wr = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      if (cpu_ack) n_cack++;
      if (dbg_ack) n_dack++;
      if (mem_memwr) n_wr++;
    end
    check("t5 acks after rst", n_cack + n_dack, 0);
    check("t5 writes after rst", n_wr, 0);
    check("t5 store suppressed", last_wr_addr, 32'h84);

    // T6: four contended rounds from reset; acks alternate CPU, DBG
    tick(); rst = 1'b1; idle_inputs();
    n_cack = 0; n_dack = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      rst = 1'b0;
      cpu_req = 1'b1; cpu_addr = 32'h100; cpu_memop = MEMOP_LW;
      dbg_req = 1'b1; dbg_addr = 32'h200; dbg_memop = MEMOP_LW;
      @(negedge clk);
      if (cpu_ack) n_cack++;
      if (dbg_ack) n_dack++;
      if (k % 4 == 3) begin
        check($sformatf("t6 cyc%0d cpu_ack", k), {31'd0, cpu_ack}, ((k / 4) % 2 == 0) ? 32'd1 : 32'd0);
        check($sformatf("t6 cyc%0d dbg_ack", k), {31'd0, dbg_ack}, ((k / 4) % 2 == 1) ? 32'd1 : 32'd0);
      end
    end
    tick(); idle_inputs();
    @(negedge clk);
    check("t6 cpu_ack total", n_cack, 4);
    check("t6 dbg_ack total", n_dack, 4);
`ifdef DMEM_ARB_PERF_EN
    e_pc = 32'd4; e_pd = 32'd4; e_pf = 32'd8;
`else
    e_pc = 32'd0; e_pd = 32'd0; e_pf = 32'd0;
`endif
    check("t6 perf_cpu_cnt", perf_cpu_cnt, e_pc);
    check("t6 perf_dbg_cnt", perf_dbg_cnt, e_pd);
    check("t6 perf_conf_cnt", perf_conf_cnt, e_pf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
